// File: rtl/uncache_unit.sv
// uncache_unit: runs one bridge transfer for each uncached core data access.
// It stalls the core while the transfer is outstanding and holds the last
// read result on uc_rdata. Byte-enable writes become size/address form.
module uncache_unit #(
    parameter bit RD_WORD_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uncached,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] uc_rdata,
    output logic        stallreq_uncache,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      r_state, w_next;
    logic        w_go;
    logic        w_cv_wr;
    logic [1:0]  w_cv_size;
    logic [1:0]  w_cv_off;
    logic [31:0] w_cv_addr;
    logic [31:0] w_cv_wdata;

    logic        r_req, r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, r_uc_rdata;
    logic [3:0]  r_wstrb;

    assign w_go = data_sram_en & uncached & (r_state == S_IDLE);

    // Convert the core's byte-enable form into bridge size/address form
    always_comb begin
        w_cv_wr    = 1'b1;
        w_cv_size  = 2'd2;
        w_cv_off   = 2'b00;
        w_cv_wdata = data_sram_wdata;
        case (data_sram_wen)
            4'b0000: begin w_cv_wr = 1'b0; w_cv_wdata = 32'd0; end
            4'b0001: begin w_cv_size = 2'd0; w_cv_off = 2'b00; end
            4'b0010: begin w_cv_size = 2'd0; w_cv_off = 2'b01; end
            4'b0100: begin w_cv_size = 2'd0; w_cv_off = 2'b10; end
            4'b1000: begin w_cv_size = 2'd0; w_cv_off = 2'b11; end
            4'b0011: begin w_cv_size = 2'd1; w_cv_off = 2'b00; end
            4'b1100: begin w_cv_size = 2'd1; w_cv_off = 2'b10; end
            // full word and irregular masks go out as a word with raw strobes
            default: begin w_cv_size = 2'd2; w_cv_off = 2'b00; end
        endcase
        // unaligned reads keep the core address only when word alignment is off
        if (!w_cv_wr && !RD_WORD_ALIGN)
            w_cv_addr = data_sram_addr;
        else
            w_cv_addr = {data_sram_addr[31:2], w_cv_off};
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic and stall request
    always_comb begin
        w_next           = r_state;
        stallreq_uncache = w_go | (r_state == S_REQ) | (r_state == S_WAIT);
        case (r_state)
            S_IDLE: if (w_go) w_next = S_REQ;
            S_REQ:  if (addr_ok) w_next = data_ok ? S_DONE : S_WAIT;
            S_WAIT: if (data_ok) w_next = S_DONE;
            // DONE lets the pipeline move past the access that is still visible
            default: w_next = S_IDLE;
        endcase
    end

    // Bridge request fields and read-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req      <= 1'b0;
            r_wr       <= 1'b0;
            r_size     <= 2'd0;
            r_addr     <= 32'd0;
            r_wstrb    <= 4'd0;
            r_wdata    <= 32'd0;
            r_uc_rdata <= 32'd0;
        end else begin
            if (w_go) begin
                r_req   <= 1'b1;
                r_wr    <= w_cv_wr;
                r_size  <= w_cv_size;
                r_addr  <= w_cv_addr;
                r_wstrb <= data_sram_wen;
                r_wdata <= w_cv_wdata;
            end
            if (r_state == S_REQ && addr_ok) begin
                r_req <= 1'b0;
                if (data_ok && !r_wr) r_uc_rdata <= rdata;
            end
            if (r_state == S_WAIT && data_ok && !r_wr)
                r_uc_rdata <= rdata;
        end
    end

    assign req      = r_req;
    assign wr       = r_wr;
    assign size     = r_size;
    assign addr     = r_addr;
    assign wstrb    = r_wstrb;
    assign wdata    = r_wdata;
    assign uc_rdata = r_uc_rdata;

endmodule

// File: tb/tb_uncache_unit.sv
// Bench for uncache_unit: table of conversion vectors, hand sequences for the
// multi-cycle corners, and randomized accesses checked against a reference model.
module tb_uncache_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        uncached, data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic [31:0] uc_rdata;
    logic        stallreq_uncache;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    int errs   = 0;
    int checks = 0;
    int hs_cnt = 0;
    int exp_hs = 0;
    logic [31:0] m_rdata = 32'd0;

    always #5 clk = ~clk;

    uncache_unit #(.RD_WORD_ALIGN(1'b1)) dut (
        .clk(clk), .reset(reset), .uncached(uncached),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .uc_rdata(uc_rdata), .stallreq_uncache(stallreq_uncache),
        .req(req), .wr(wr), .size(size), .addr(addr), .wstrb(wstrb),
        .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
    );

    // count accepted bridge requests
    always @(posedge clk) if (!reset && req && addr_ok) hs_cnt <= hs_cnt + 1;

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] a;
        logic [31:0] wd;
        logic        e_wr;
        logic [1:0]  e_size;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // reference conversion straight from the access rules
    task automatic model_conv(input logic [3:0] wen, input logic [31:0] a,
                              output logic e_wr, output logic [1:0] e_size,
                              output logic [31:0] e_addr);
        int pos;
        pos = 0;
        for (int i = 0; i < 4; i++) if (wen[i]) pos = i;
        e_wr = (wen != 4'd0);
        if (wen == 4'd0) begin e_size = 2; e_addr = a & 32'hFFFF_FFFC; end
        else if ($countones(wen) == 1) begin e_size = 0; e_addr = (a & 32'hFFFF_FFFC) + pos; end
        else if (wen == 4'b0011) begin e_size = 1; e_addr = a & 32'hFFFF_FFFC; end
        else if (wen == 4'b1100) begin e_size = 1; e_addr = (a & 32'hFFFF_FFFC) + 2; end
        else begin e_size = 2; e_addr = a & 32'hFFFF_FFFC; end
    endtask

    // one full uncached access: go cycle, REQ cycles, WAIT cycles, DONE cycle
    task automatic access(input vec_t v, input int aok, input int dok,
                          input logic [31:0] rd, input bit noise);
        logic [31:0] e_wd;
        e_wd = v.e_wr ? v.wd : 32'd0;
        @(negedge clk);
        data_sram_en = 1; uncached = 1; data_sram_wen = v.wen;
        data_sram_addr = v.a; data_sram_wdata = v.wd;
        addr_ok = 0; data_ok = 0; rdata = $urandom;
        #1;
        chk("go_stall", stallreq_uncache, 1);
        chk("go_req", req, 0);
        for (int k = 0; k <= aok; k++) begin
            @(negedge clk);
            addr_ok = (k == aok);
            data_ok = (k == aok) && (dok == 0);
            rdata = data_ok ? rd : $urandom;
            #1;
            chk("req", req, 1);
            chk("wr", wr, v.e_wr);
            chk("size", size, v.e_size);
            chk("addr", addr, v.e_addr);
            chk("wstrb", wstrb, v.e_strb);
            chk("wdata", wdata, e_wd);
            chk("req_stall", stallreq_uncache, 1);
        end
        for (int j = 1; j <= dok; j++) begin
            @(negedge clk);
            addr_ok = 0; data_ok = (j == dok);
            rdata = data_ok ? rd : $urandom;
            #1;
            chk("wait_req", req, 0);
            chk("wait_stall", stallreq_uncache, 1);
        end
        if (!v.e_wr) m_rdata = rd;
        exp_hs++;
        @(negedge clk);
        addr_ok = 0; data_ok = noise; rdata = $urandom;
        #1;
        chk("done_stall", stallreq_uncache, 0);
        chk("done_req", req, 0);
        chk("done_rdata", uc_rdata, m_rdata);
        chk("handshakes", hs_cnt, exp_hs);
    endtask

    // cycles without an uncached access; data_ok noise must be ignored
    task automatic quiet(input int n, input bit cached);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data_sram_en = cached; uncached = 0; data_sram_wen = 4'($urandom);
            data_sram_addr = $urandom; addr_ok = 0;
            data_ok = 1'($urandom); rdata = $urandom;
            #1;
            chk("quiet_stall", stallreq_uncache, 0);
            chk("quiet_req", req, 0);
            chk("quiet_rdata", uc_rdata, m_rdata);
        end
        chk("quiet_hs", hs_cnt, exp_hs);
    endtask

    initial begin
        vec_t tbl[10];
        vec_t v;
        tbl[0] = '{4'b0001, 32'h1FAF_F003, 32'h0000_00AB, 1, 0, 32'h1FAF_F000, 4'b0001};
        tbl[1] = '{4'b0010, 32'h1FAF_F000, 32'h0000_AB00, 1, 0, 32'h1FAF_F001, 4'b0010};
        tbl[2] = '{4'b0100, 32'h1FAF_F000, 32'h00AB_0000, 1, 0, 32'h1FAF_F002, 4'b0100};
        tbl[3] = '{4'b1000, 32'h1FAF_F001, 32'hAB00_0000, 1, 0, 32'h1FAF_F003, 4'b1000};
        tbl[4] = '{4'b0011, 32'h1FAF_F002, 32'h0000_1234, 1, 1, 32'h1FAF_F000, 4'b0011};
        tbl[5] = '{4'b1100, 32'h1FAF_F000, 32'h1234_0000, 1, 1, 32'h1FAF_F002, 4'b1100};
        tbl[6] = '{4'b1111, 32'h1FAF_F003, 32'hCAFE_F00D, 1, 2, 32'h1FAF_F000, 4'b1111};
        tbl[7] = '{4'b0101, 32'h1FAF_F001, 32'h0055_0055, 1, 2, 32'h1FAF_F000, 4'b0101};
        tbl[8] = '{4'b0110, 32'h1FAF_F002, 32'h0066_6600, 1, 2, 32'h1FAF_F000, 4'b0110};
        tbl[9] = '{4'b0000, 32'h1FAF_0002, 32'h1111_2222, 0, 2, 32'h1FAF_0000, 4'b0000};

        reset = 1; uncached = 0; data_sram_en = 0; data_sram_wen = 0;
        data_sram_addr = 0; data_sram_wdata = 0; addr_ok = 0; data_ok = 0; rdata = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", req, 0);
        chk("rst_wr", wr, 0);
        chk("rst_size", size, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wstrb", wstrb, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_rdata", uc_rdata, 0);
        chk("rst_stall", stallreq_uncache, 0);
        data_sram_en = 1; uncached = 1;
        #1;
        chk("rst_go_stall", stallreq_uncache, 1);
        @(negedge clk);
        data_sram_en = 0; uncached = 0; reset = 0;
        quiet(2, 0);

        // conversion table, minimum latency
        for (int i = 0; i < 10; i++) access(tbl[i], 0, 0, 32'hA5A5_0000 + i, 0);
        quiet(1, 0);

        // read with addr_ok at T+1, data_ok at T+3
        access(tbl[9], 0, 2, 32'hDEAD_BEEF, 1);
        chk("read_result", uc_rdata, 32'hDEAD_BEEF);
        quiet(1, 1);

        // addr_ok held off for 5 cycles
        access(tbl[2], 5, 1, 32'h0, 0);
        chk("write_keeps_rdata", uc_rdata, 32'hDEAD_BEEF);

        // back-to-back loads, then cached traffic
        v = tbl[9]; v.a = 32'h1FAF_0010; v.e_addr = 32'h1FAF_0010;
        access(v, 1, 0, 32'h1234_5678, 0);
        access(v, 0, 1, 32'h8765_4321, 0);
        chk("b2b_overwrite", uc_rdata, 32'h8765_4321);
        quiet(4, 1);

        // reset while waiting for data_ok
        @(negedge clk);
        data_sram_en = 1; uncached = 1; data_sram_wen = 0; data_sram_addr = 32'h1FAF_0004;
        addr_ok = 0; data_ok = 0;
        @(negedge clk);
        addr_ok = 1;
        @(negedge clk);
        addr_ok = 0;
        #1;
        chk("pre_rst_stall", stallreq_uncache, 1);
        reset = 1; data_sram_en = 0; uncached = 0;
        @(negedge clk);
        reset = 0; m_rdata = 0; exp_hs = hs_cnt;
        #1;
        chk("rst_wait_req", req, 0);
        chk("rst_wait_rdata", uc_rdata, 0);
        chk("rst_wait_stall", stallreq_uncache, 0);
        quiet(2, 0);

        // randomized accesses against the reference model
        for (int n = 0; n < 60; n++) begin
            v.wen = $urandom_range(0, 1) ? 4'd0 : 4'($urandom);
            v.a = $urandom;
            v.wd = $urandom;
            v.e_strb = v.wen;
            model_conv(v.wen, v.a, v.e_wr, v.e_size, v.e_addr);
            access(v, $urandom_range(0, 4), $urandom_range(0, 3), $urandom, 1'($urandom));
            if ($urandom_range(0, 2) == 0) quiet($urandom_range(1, 3), 1'($urandom));
        end

        quiet(2, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/uncache_unit.md
# uncache_unit

Services the core's uncached data accesses (device/MMIO space) between the core's data SRAM-like port and the AXI bridge's SRAM-like master port. Sits downstream of the core next to the dcache: when the core issues a data access flagged uncached, this block raises `stallreq_uncache`, performs exactly one transfer on the bridge port, and returns read data. It converts the core's byte-enable write form into size/address form and holds the result until the pipeline advances.

## Interface
Parameters:
- `RD_WORD_ALIGN`, 1, when 1 every read is issued as a 4-byte read with `addr[1:0]` forced to 0; the core extracts bytes/halves.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `uncached`  in  1  current core data access targets uncached space (decoded upstream from physical address).
- `data_sram_en`  in  1  core data access valid.
- `data_sram_wen`  in  4  byte write enables; 0 = read.
- `data_sram_addr`  in  32  physical address.
- `data_sram_wdata`  in  32  write data, byte-lane aligned.
- `uc_rdata`  out  32  read data returned to the core.
- `stallreq_uncache`  out  1  stall request to the core.
- `req`  out  1  bridge request.
- `wr`  out  1  1 = write, 0 = read.
- `size`  out  2  0 = byte, 1 = half, 2 = word.
- `addr`  out  32  transfer address.
- `wstrb`  out  4  write strobes.
- `wdata`  out  32  write data.
- `addr_ok`  in  1  bridge accepted request this cycle.
- `data_ok`  in  1  bridge completed transfer this cycle (read data or write ack).
- `rdata`  in  32  bridge read data, valid with `data_ok`.

## Operation
- Start condition `go = data_sram_en & uncached & state==IDLE`.
- FSM states IDLE, REQ, WAIT, DONE:
  - IDLE: on `go`, latch wen/addr/wdata, convert, -> REQ.
  - REQ: `req`=1 with latched fields; on `addr_ok` -> WAIT. If `addr_ok` and `data_ok` in same cycle -> DONE directly, capture `rdata`.
  - WAIT: on `data_ok` capture `rdata` into `uc_rdata` (reads only), -> DONE.
  - DONE: one cycle, `stallreq_uncache`=0 so the pipeline advances past the access; -> IDLE unconditionally. The core request still visible in DONE is not reissued.
- `stallreq_uncache = go | state==REQ | state==WAIT` (combinational, asserted in the same cycle the access first appears).
- Write conversion (wr=1, wstrb=wen): 0001/0010/0100/1000 -> size 0, addr[1:0]=00/01/10/11; 0011 -> size 1, 00; 1100 -> size 1, 10; 1111 -> size 2, 00; any other nonzero pattern -> size 2, addr[1:0]=00, wstrb passed as-is.
- Read (wen=0): wr=0, wstrb=0, size 2, addr[1:0]=00 when `RD_WORD_ALIGN`=1; otherwise the core address unchanged with size 2.
- Accesses with `uncached`=0 are ignored entirely.
- `uc_rdata` holds the last captured read value until the next read's `data_ok`; writes do not modify it.

## Timing
- Reset: state IDLE; `req`, `wr`, `size`, `addr`, `wstrb`, `wdata`, `uc_rdata` all 0; `stallreq_uncache` 0 unless `go` is true.
- Outputs `req`/`wr`/`size`/`addr`/`wstrb`/`wdata` are registered and stable from REQ entry until `addr_ok`; `req` drops the cycle after `addr_ok`.
- Minimum latency: access in cycle T, `req` at T+1, `addr_ok`+`data_ok` at T+1 -> DONE at T+2, stall low at T+2, `uc_rdata` valid from T+2.
- Stall cycles = 1 + cycles in REQ + cycles in WAIT.
- Back-to-back uncached accesses: the second appears the cycle after DONE and starts from IDLE with no bubble beyond DONE.
- `data_ok` in IDLE/DONE: ignored. `reset` in REQ/WAIT: return to IDLE, drop `req`; the bridge is reset concurrently.

## Test plan
- Read, bridge `addr_ok` T+1, `data_ok` T+3 with `rdata`=0xDEADBEEF at `data_sram_addr`=0x1FAF_0002 -> `addr`=0x1FAF_0000, `size`=2, stall high T..T+3, low T+4, `uc_rdata`=0xDEADBEEF.
- Byte write wen=0100, addr 0x1FAF_F000, wdata 0x00AB0000 -> wr=1, size 0, addr 0x1FAF_F002, wstrb 0100; single `req` handshake.
- Half writes wen=0011 and 1100 -> size 1, addr low bits 00 and 10; word write 1111 -> size 2.
- `addr_ok` held low 5 cycles -> `req`/fields stable all 5 cycles, exactly one transfer, stall held.
- Two consecutive uncached loads -> two distinct `req` handshakes, one DONE cycle between them, second result overwrites `uc_rdata`; cached access (`uncached`=0) -> no `req`, no stall.
- `reset` asserted in WAIT -> next cycle IDLE, `req`=0, `uc_rdata`=0, stall low.
